// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath controller FSM
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   Op[5:0]             opcode field of the instruction register
//   mem_ready           memory access completes this cycle
//   IorD .. RegWrite    single-bit datapath controls
//   PCSrc, ALUSrcB,     2-bit datapath selects; ALUOp: 00 add, 01 sub, 10 Funct
//   ALUOp
//   illegal_op          high during a DECODE cycle holding an unknown opcode
//   state[3:0]          current state code (debug)
//
// Build option: MC_JUMP_EN adds the JUMP state (Op=000010). Without it,
// 000010 decodes as an illegal opcode.

module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10
`ifdef MC_JUMP_EN
        ,
        S_JUMP     = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Registered control bundle:
    // {IorD, MemWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite,
    //  PCSrc[1:0], ALUSrcB[1:0], ALUOp[1:0], pcwrite_fixed}
    typedef logic [13:0] ctl_t;

    state_t cur;
    state_t nxt;
    logic   op_known;
    logic   pcwrite_fixed;
    logic   fetch_ok;

    // Moore decode of the control bundle for a given state.
    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    c[4:3]   = 2'b01;
            S_DECODE:   c[4:3]   = 2'b11;
            S_MEMADR:   begin c[10] = 1'b1; c[4:3] = 2'b10; end
            S_MEMREAD:  c[13]    = 1'b1;
            S_MEMWB:    begin c[8] = 1'b1; c[7] = 1'b1; end
            S_MEMWRITE: begin c[13] = 1'b1; c[12] = 1'b1; end
            S_EXECUTE:  begin c[10] = 1'b1; c[2:1] = 2'b10; end
            S_ALUWB:    begin c[9] = 1'b1; c[7] = 1'b1; end
            S_BRANCH:   begin c[10] = 1'b1; c[2:1] = 2'b01; c[6:5] = 2'b01; c[11] = 1'b1; end
            S_ADDIEXEC: begin c[10] = 1'b1; c[4:3] = 2'b10; end
            S_ADDIWB:   c[7]     = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP:     begin c[6:5] = 2'b10; c[0] = 1'b1; end
`endif
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_known = 1'b0;
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_known = 1'b1;
`ifdef MC_JUMP_EN
            OP_J:                                    op_known = 1'b1;
`endif
            default:                                 op_known = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXECUTE;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEXEC;
`ifdef MC_JUMP_EN
                    OP_J:         nxt = S_JUMP;
`endif
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  nxt = S_ALUWB;
            S_ADDIEXEC: nxt = S_ADDIWB;
            default:    nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register; unused codes fall into FETCH through the default arms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= S_FETCH;
            {IorD, MemWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite,
             PCSrc, ALUSrcB, ALUOp, pcwrite_fixed} <= ctl_for(S_FETCH);
        end else begin
            cur <= nxt;
            {IorD, MemWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite,
             PCSrc, ALUSrcB, ALUOp, pcwrite_fixed} <= ctl_for(nxt);
        end
    end

    // FETCH write enables follow mem_ready within the cycle and are held off
    // while reset is asserted so no instruction is latched during reset.
    assign fetch_ok   = (cur == S_FETCH) && mem_ready && rst_n;
    assign IRWrite    = fetch_ok;
    assign PCWrite    = fetch_ok || pcwrite_fixed;
    // The opcode only becomes valid in DECODE, after IR was written.
    assign illegal_op = (cur == S_DECODE) && !op_known;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       illegal_op;
    logic [3:0] state;
    logic [15:0] act;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rstn;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state(state)
    );

    // {IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg,
    //  RegWrite, PCSrc[1:0], ALUSrcB[1:0], ALUOp[1:0], illegal_op}
    assign act = {IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg,
                  RegWrite, PCSrc, ALUSrcB, ALUOp, illegal_op};

    function automatic logic known(input logic [5:0] op);
        if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI)
            return 1'b1;
`ifdef MC_JUMP_EN
        if (op == OP_J) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Control table of the datapath, one line per state code.
    function automatic logic [15:0] model(input logic [3:0] st, input logic mr,
                                         input logic [5:0] op, input logic rstn);
        logic [15:0] o;
        o = '0;
        case (st)
            4'd0:  begin o[4:3] = 2'b01; o[13] = mr & rstn; o[12] = mr & rstn; end
            4'd1:  begin o[4:3] = 2'b11; o[0] = ~known(op); end
            4'd2:  begin o[10] = 1'b1; o[4:3] = 2'b10; end
            4'd3:  o[15] = 1'b1;
            4'd4:  begin o[8] = 1'b1; o[7] = 1'b1; end
            4'd5:  begin o[15] = 1'b1; o[14] = 1'b1; end
            4'd6:  begin o[10] = 1'b1; o[2:1] = 2'b10; end
            4'd7:  begin o[9] = 1'b1; o[7] = 1'b1; end
            4'd8:  begin o[10] = 1'b1; o[2:1] = 2'b01; o[6:5] = 2'b01; o[11] = 1'b1; end
            4'd9:  begin o[10] = 1'b1; o[4:3] = 2'b10; end
            4'd10: o[7] = 1'b1;
            4'd11: begin o[6:5] = 2'b10; o[12] = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic add(input logic rstn, input logic [5:0] op, input logic mr, input logic [3:0] st);
        vec_t v;
        v.rstn = rstn; v.op = op; v.mr = mr; v.st = st;
        vecs.push_back(v);
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Expected cycle trace of one instruction, built from its phase list
    // with randomly chosen memory wait counts.
    task automatic gen_instr(input logic [5:0] op);
        int w;
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) add(1'b1, rop(), 1'b0, 4'd0);
        add(1'b1, rop(), 1'b1, 4'd0);
        add(1'b1, op, rbit(), 4'd1);
        if (op == OP_R) begin
            add(1'b1, rop(), rbit(), 4'd6);
            add(1'b1, rop(), rbit(), 4'd7);
        end else if (op == OP_BEQ) begin
            add(1'b1, rop(), rbit(), 4'd8);
        end else if (op == OP_ADDI) begin
            add(1'b1, rop(), rbit(), 4'd9);
            add(1'b1, rop(), rbit(), 4'd10);
        end else if (op == OP_LW || op == OP_SW) begin
            add(1'b1, op, rbit(), 4'd2);
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) add(1'b1, rop(), 1'b0, (op == OP_LW) ? 4'd3 : 4'd5);
            add(1'b1, rop(), 1'b1, (op == OP_LW) ? 4'd3 : 4'd5);
            if (op == OP_LW) add(1'b1, rop(), rbit(), 4'd4);
        end else if (known(op)) begin
            add(1'b1, rop(), rbit(), 4'd11);
        end
    endtask

    task automatic run_vecs(input string tag);
        vec_t v;
        logic [15:0] exp_o;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst_n = v.rstn; Op = v.op; mem_ready = v.mr;
            @(negedge clk);
            exp_o = model(v.st, v.mr, v.op, v.rstn);
            checks++;
            if (state !== v.st) begin
                errors++;
                $display("FAIL %s[%0d] state: got %0d expected %0d", tag, i, state, v.st);
            end
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL %s[%0d] outputs (state %0d): got %h expected %h", tag, i, v.st, act, exp_o);
            end
        end
        vecs.delete();
    endtask

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; Op = OP_R; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Directed table: {rst_n, Op, mem_ready, expected current state}
        add(1, OP_R, 0, 0); add(1, OP_R, 1, 0); add(1, OP_R, 1, 1); add(1, OP_R, 1, 6); add(1, OP_R, 1, 7);
        add(1, OP_LW, 1, 0); add(1, OP_LW, 1, 1); add(1, OP_LW, 1, 2);
        add(1, OP_LW, 0, 3); add(1, OP_LW, 0, 3); add(1, OP_LW, 1, 3); add(1, OP_LW, 1, 4);
        add(1, OP_SW, 1, 0); add(1, OP_SW, 1, 1); add(1, OP_SW, 1, 2);
        add(1, OP_LW, 0, 5); add(1, OP_R, 0, 5); add(1, OP_SW, 0, 5); add(1, OP_SW, 1, 5);
        add(1, OP_BEQ, 1, 0); add(1, OP_BEQ, 1, 1); add(1, OP_BEQ, 1, 8);
        add(1, OP_ADDI, 1, 0); add(1, OP_ADDI, 1, 1); add(1, OP_ADDI, 1, 9); add(1, OP_ADDI, 1, 10);
        add(1, OP_BAD, 1, 0); add(1, OP_BAD, 1, 1);
        add(1, OP_J, 1, 0); add(1, OP_J, 1, 1);
`ifdef MC_JUMP_EN
        add(1, OP_J, 1, 11);
`endif
        // reset while waiting in MEMREAD
        add(1, OP_LW, 1, 0); add(1, OP_LW, 1, 1); add(1, OP_LW, 1, 2); add(0, OP_LW, 0, 3); add(1, OP_LW, 0, 0);
        // reset while waiting in MEMWRITE, then reset held in FETCH with mem_ready=1
        add(1, OP_SW, 1, 0); add(1, OP_SW, 1, 1); add(1, OP_SW, 0, 2); add(0, OP_SW, 0, 5);
        add(0, OP_SW, 1, 0);
        add(1, OP_R, 1, 0); add(1, OP_R, 1, 1); add(1, OP_R, 1, 6); add(1, OP_R, 1, 7); add(1, OP_R, 0, 0);
        run_vecs("table");

        // Randomized instruction stream against the phase-list model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: op = rop();
            endcase
            gen_instr(op);
        end
        run_vecs("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
